// File: rtl/fifo_pack.sv
// rtl/fifo_pack.sv - width up-converting FIFO packing narrow chunks LSB-first into wide words
// Optional zero-padded flush of a partial word when FIFO_PACK_FLUSH_EN is defined.
module fifo_pack #(
  parameter int DATA_IN_WIDTH  = 4,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int DEPTH          = 8,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                      rd_en,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic                      flush,
`endif
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      empty,
  output logic                      full,
  output logic [ADDR_WIDTH:0]       level,
  output logic                      partial
);

  localparam int CHUNK_COUNT = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int CW          = $clog2(CHUNK_COUNT);

  logic [DATA_OUT_WIDTH-1:0] mem [DEPTH];

  logic [DATA_OUT_WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]             chunk_idx_q, chunk_idx_d;
  logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]       level_q, level_d;
  logic [DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                      data_valid_q, data_valid_d;

  logic                      chunk_acc, last_chunk, flush_push, push, pop;
  logic [DATA_OUT_WIDTH-1:0] merged;

  assign full    = (level_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign partial = (chunk_idx_q != '0);

  assign chunk_acc  = wr_en && !full;
  assign last_chunk = chunk_acc && (chunk_idx_q == CW'(CHUNK_COUNT - 1));
`ifdef FIFO_PACK_FLUSH_EN
  assign flush_push = flush && partial && !full;
`else
  assign flush_push = 1'b0;
`endif
  // Upper chunks of the assembly register are always zero, so a flush pads for free.
  assign push = last_chunk || flush_push;
  assign pop  = rd_en && !empty;

  always_comb begin
    merged = asm_q;
    for (int k = 0; k < CHUNK_COUNT; k++) begin
      if (chunk_acc && (chunk_idx_q == CW'(k))) begin
        merged[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
      end
    end
  end

  always_comb begin
    asm_d        = asm_q;
    chunk_idx_d  = chunk_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (push) begin
      asm_d       = '0;
      chunk_idx_d = '0;
      wr_ptr_d    = wr_ptr_q + 1'b1;
    end else if (chunk_acc) begin
      asm_d       = merged;
      chunk_idx_d = chunk_idx_q + 1'b1;
    end

    if (pop) begin
      data_out_d   = mem[rd_ptr_q];
      data_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q        <= '0;
      chunk_idx_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      chunk_idx_q  <= chunk_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= merged;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign level      = level_q;

endmodule

// File: tb/tb_fifo_pack.sv
// tb/tb_fifo_pack.sv - directed self-checking bench for fifo_pack
// Flush scenario is exercised only when FIFO_PACK_FLUSH_EN is defined.
module tb_fifo_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  data_in;
  logic        rd_en;
  logic [15:0] data_out;
  logic        data_valid;
  logic        empty;
  logic        full;
  logic [3:0]  level;
  logic        partial;
`ifdef FIFO_PACK_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  fifo_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
`ifdef FIFO_PACK_FLUSH_EN
    .flush      (flush),
`endif
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .partial    (partial)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chunk(input logic [3:0] v);
    wr_en = 1'b1;
    data_in = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic push_word_nibble(input logic [3:0] v);
    for (int c = 0; c < 4; c++) push_chunk(v);
  endtask

  task automatic test_reset();
    checks++;
    if ({empty, full, level, partial, data_valid} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags got e=%b f=%b l=%0d p=%b v=%b exp e=1 f=0 l=0 p=0 v=0",
               empty, full, level, partial, data_valid);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data_out got %h exp 0000", data_out);
    end
  endtask

  task automatic test_basic();
    push_chunk(4'h1);
    push_chunk(4'h2);
    push_chunk(4'h3);
    checks++;
    if (empty !== 1'b1 || partial !== 1'b1) begin
      errors++;
      $display("FAIL basic_partial got empty=%b partial=%b exp empty=1 partial=1", empty, partial);
    end
    push_chunk(4'h4);
    checks++;
    if (empty !== 1'b0 || level !== 4'd1 || partial !== 1'b0) begin
      errors++;
      $display("FAIL basic_pushed got empty=%b level=%0d partial=%b exp 0 1 0", empty, level, partial);
    end
    pop_word();
    checks++;
    if (data_out !== 16'h4321 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_read got %h valid=%b exp 4321 valid=1", data_out, data_valid);
    end
    checks++;
    if (level !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_drained got level=%0d empty=%b exp 0 1", level, empty);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 16'h4321) begin
      errors++;
      $display("FAIL basic_hold got %h valid=%b exp 4321 valid=0", data_out, data_valid);
    end
  endtask

  task automatic test_full_wrap();
    logic [3:0]  nib;
    logic [15:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      for (int w = 0; w < 8; w++) begin
        nib = 4'(w + 8 * pass);
        push_word_nibble(nib);
      end
      checks++;
      if (full !== 1'b1 || level !== 4'd8) begin
        errors++;
        $display("FAIL full_set pass %0d got full=%b level=%0d exp 1 8", pass, full, level);
      end
      for (int c = 0; c < 4; c++) push_chunk(4'h5);
      checks++;
      if (level !== 4'd8 || partial !== 1'b0) begin
        errors++;
        $display("FAIL full_drop pass %0d got level=%0d partial=%b exp 8 0", pass, level, partial);
      end
      for (int w = 0; w < 8; w++) begin
        nib = 4'(w + 8 * pass);
        exp = {4{nib}};
        pop_word();
        checks++;
        if (data_out !== exp || data_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_read pass %0d word %0d got %h valid=%b exp %h", pass, w, data_out, data_valid, exp);
        end
      end
      checks++;
      if (empty !== 1'b1 || level !== 4'd0) begin
        errors++;
        $display("FAIL wrap_empty pass %0d got empty=%b level=%0d exp 1 0", pass, empty, level);
      end
    end
  endtask

  task automatic test_noop();
    logic [15:0] exp;
    pop_word();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 16'hFFFF || level !== 4'd0) begin
      errors++;
      $display("FAIL empty_read got %h valid=%b level=%0d exp ffff 0 0", data_out, data_valid, level);
    end
    for (int w = 0; w < 8; w++) push_word_nibble(4'(w + 1));
    push_chunk(4'h3);
    checks++;
    if (level !== 4'd8 || partial !== 1'b0) begin
      errors++;
      $display("FAIL full_write got level=%0d partial=%b exp 8 0", level, partial);
    end
    wr_en = 1'b1;
    data_in = 4'h3;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++;
    if (level !== 4'd7 || partial !== 1'b0 || full !== 1'b0 || data_out !== 16'h1111) begin
      errors++;
      $display("FAIL full_rw got level=%0d partial=%b full=%b data=%h exp 7 0 0 1111",
               level, partial, full, data_out);
    end
    for (int w = 1; w < 8; w++) begin
      exp = {4{4'(w + 1)}};
      pop_word();
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL full_drain word %0d got %h exp %h", w, data_out, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int w = 0; w < 4; w++) push_word_nibble(4'(w + 2));
    for (int c = 0; c < 3; c++) push_chunk(4'h6);
    checks++;
    if (level !== 4'd4 || partial !== 1'b1) begin
      errors++;
      $display("FAIL b2b_setup got level=%0d partial=%b exp 4 1", level, partial);
    end
    wr_en = 1'b1;
    data_in = 4'h6;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++;
    if (level !== 4'd4 || partial !== 1'b0 || data_out !== 16'h2222 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_simul got level=%0d partial=%b data=%h valid=%b exp 4 0 2222 1",
               level, partial, data_out, data_valid);
    end
    for (int w = 1; w < 5; w++) begin
      exp = {4{4'(w + 2)}};
      pop_word();
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL b2b_drain word %0d got %h exp %h", w, data_out, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_chunk(4'h5);
    push_chunk(4'h6);
    checks++;
    if (partial !== 1'b1) begin
      errors++;
      $display("FAIL mid_partial got %b exp 1", partial);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({empty, full, level, partial, data_valid} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}
        || data_out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset got e=%b f=%b l=%0d p=%b v=%b d=%h exp 1 0 0 0 0 0000",
               empty, full, level, partial, data_valid, data_out);
    end
    tick();
    rst_n = 1'b1;
    push_chunk(4'h9);
    push_chunk(4'hA);
    push_chunk(4'hB);
    push_chunk(4'hC);
    pop_word();
    checks++;
    if (data_out !== 16'hCBA9 || level !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got %h level=%0d exp cba9 0", data_out, level);
    end
  endtask

`ifdef FIFO_PACK_FLUSH_EN
  task automatic test_flush();
    push_chunk(4'hA);
    push_chunk(4'hB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (level !== 4'd1 || partial !== 1'b0) begin
      errors++;
      $display("FAIL flush_push got level=%0d partial=%b exp 1 0", level, partial);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL flush_idle got level=%0d exp 1", level);
    end
    pop_word();
    checks++;
    if (data_out !== 16'h00BA) begin
      errors++;
      $display("FAIL flush_read got %h exp 00ba", data_out);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    data_in = 4'h0;
`ifdef FIFO_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_full_wrap();
    test_noop();
    test_back_to_back();
    test_reset_mid();
`ifdef FIFO_PACK_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pack.md
# fifo_pack

Width up-converting FIFO that accepts narrow chunks (DATA_IN_WIDTH) and stores them as wide words (DATA_OUT_WIDTH), packing chunks LSB-first. It is the write-side counterpart of the chunk-slicing FIFO in the neural-net datapath: narrow producers (serial weight/activation streams) feed it, and wide consumers pop fully assembled words.

## Interface
- DATA_IN_WIDTH, 4, chunk width; DATA_OUT_WIDTH must be an integer multiple of it
- DATA_OUT_WIDTH, 16, stored/output word width; CHUNK_COUNT = DATA_OUT_WIDTH/DATA_IN_WIDTH, must be ≥ 2
- DEPTH, 8, number of wide words stored; power of two; ADDR_WIDTH = $clog2(DEPTH)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  chunk write request
- data_in  in  DATA_IN_WIDTH  chunk
- rd_en  in  1  word read request
- data_out  out  DATA_OUT_WIDTH  registered read word
- data_valid  out  1  one-cycle pulse, data_out updated this cycle
- empty  out  1  no complete words stored
- full  out  1  DEPTH complete words stored; chunks refused
- level  out  ADDR_WIDTH+1  number of complete words stored (0..DEPTH)
- partial  out  1  assembly register holds ≥ 1 chunk not yet pushed
- flush  in  1  present only with FIFO_PACK_FLUSH_EN (see Configuration)

## Operation
- Chunk accepted when wr_en && !full. Chunk k (k = 0..CHUNK_COUNT-1) lands at bits [k*DATA_IN_WIDTH +: DATA_IN_WIDTH] of the assembly register; chunk index increments.
- On acceptance of chunk CHUNK_COUNT-1: completed word (assembly register with this chunk merged) written to memory[wr_ptr], wr_ptr+1 (wraps mod DEPTH), level+1, chunk index → 0, assembly register cleared.
- Word popped when rd_en && !empty: data_out <= memory[rd_ptr], rd_ptr+1 (wraps), level-1, data_valid=1 next cycle.
- Simultaneous push and pop: both occur, level unchanged, flags unchanged.
- full/empty derived from level (registered): full = (level==DEPTH), empty = (level==0). Gating uses flag values at the clock edge, so a pop while full does not allow a chunk in the same cycle.
- wr_en while full: chunk dropped, no state change. rd_en while empty: no pop, data_out holds, data_valid=0.
- Partial words are never visible on the read side; empty stays 1 while only partial chunks exist.
- partial = (chunk index != 0).

## Timing
- Reset (rst_n low, asynchronous): data_out=0, data_valid=0, empty=1, full=0, level=0, partial=0, pointers and chunk index 0, assembly register 0. Memory contents not reset. Reset mid-assembly discards partial chunks.
- Write-to-read latency: word whose last chunk is accepted at edge N sets empty=0 after edge N; earliest pop at edge N+1, data_out/data_valid visible after edge N+1.
- Read latency: 1 cycle from rd_en accepted to data_out/data_valid.
- Throughput: one chunk per cycle in, one word per cycle out.
- data_out holds last popped word until next pop.

## Configuration
- FIFO_PACK_FLUSH_EN defined: flush input present. flush && partial && !full (same edge) pushes the assembly register with unfilled upper chunks zero-padded; chunk index → 0. If wr_en is accepted in the same cycle, the chunk is merged first; if it completes the word, a single normal push occurs (no extra empty word). flush with partial=0 or full=1: no effect, partial chunks retained.
- Not defined: no flush port; words are pushed only on CHUNK_COUNT accepted chunks.

## Test plan
- After reset, chunks 0x1,0x2,0x3,0x4 on 4 cycles, then rd_en -> empty falls after 4th chunk, data_out=0x4321, data_valid one cycle, level 1→0, empty=1.
- Write 32 chunks (8 words, word i = {i,i,i,i}) -> full=1, level=8; 4 more chunks dropped; 8 reads return 0x0000..0x7777 in order, pointer wraparound verified over second fill.
- rd_en on empty and wr_en on full -> no state change, data_valid=0, data_out holds previous value.
- Level 4, last chunk of a word and rd_en in same cycle -> level stays 4, correct word popped; with full=1, rd_en+wr_en -> pop only, chunk dropped, level 7.
- Chunks 0x5,0x6 then rst_n low mid-cycle -> all outputs at reset values immediately, partial=0; next 4 chunks 0x9,0xA,0xB,0xC read back as 0xCBA9.
- FIFO_PACK_FLUSH_EN: chunks 0xA,0xB then flush -> word 0x00BA stored, partial=0; flush with partial=0 -> level unchanged.
